combination_lock_param: RTL and testbench

Parametrised, reprogrammable combination lock FSM for the lock subsystem. Accepts a `NUM_DIGITS`-digit code one digit per `Enter` strobe, compares the full sequence only after the last digit (no early-fail leakage), and counts failed attempts with a timed lockout after `MAX_TRIES`. While open, the code can be reprogrammed through a shadow register committed atomically.

---
 rtl/combination_lock_param_if.sv | 33 +++
 rtl/combination_lock_param.sv | 171 +++++++++++++++++
 tb/tb_combination_lock_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/combination_lock_param_if.sv
// Keypad/status bundle between a lock controller and its keypad front end.
// master drives digits and commands; slave (the lock) returns status.
interface combination_lock_param_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 3
);
    localparam int DC_W = $clog2(NUM_DIGITS + 1);
    localparam int FC_W = $clog2(MAX_TRIES + 1);

    logic               Enter;
    logic [DIGIT_W-1:0] Digit;
    logic               Relock;
    logic               Prog;
    logic [1:0]         State;
    logic               Unlocked;
    logic               Lockout;
    logic               Alarm;
    logic [DC_W-1:0]    DigitCount;
    logic [FC_W-1:0]    FailCount;

    modport master (
        output Enter, Digit, Relock, Prog,
        input  State, Unlocked, Lockout, Alarm,
        input  DigitCount, FailCount
    );

    modport slave (
        input  Enter, Digit, Relock, Prog,
        output State, Unlocked, Lockout, Alarm,
        output DigitCount, FailCount
    );
endinterface

// File: rtl/combination_lock_param.sv
// Reprogrammable N-digit combination lock with failure lockout.
// Define COMBO_LOCK_TIMEOUT_EN to abandon idle partial entries.
module combination_lock_param #(
    parameter int                              DIGIT_W        = 4,
    parameter int                              NUM_DIGITS     = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h197D,
    parameter int                              MAX_TRIES      = 3,
    parameter int                              LOCKOUT_CYCLES = 16,
    parameter int                              ENTRY_TIMEOUT  = 64
) (
    input logic                    Clk,
    input logic                    Reset_n,
    combination_lock_param_if.slave bus
);
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int DC_W   = $clog2(NUM_DIGITS + 1);
    localparam int FC_W   = $clog2(MAX_TRIES + 1);
    localparam int TM_W   = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DC_W-1:0] LAST     = DC_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0] TRIES    = FC_W'(MAX_TRIES);
    localparam logic [FC_W-1:0] TRIES_M1 = FC_W'(MAX_TRIES - 1);
    localparam logic [TM_W-1:0] LOAD     = TM_W'(LOCKOUT_CYCLES);

    if (NUM_DIGITS < 2 || MAX_TRIES < 1 ||
        LOCKOUT_CYCLES < 1 || ENTRY_TIMEOUT < 1) begin : g_param_err
        $error("combination_lock_param: illegal parameters");
    end

    typedef enum logic [1:0] {
        ENTRY   = 2'b00,
        OPEN    = 2'b01,
        PROG    = 2'b10,
        LOCKOUT = 2'b11
    } state_t;

    state_t            state_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] shadow_q;
    logic [CODE_W-1:0] shadow_nxt;
    logic [DC_W-1:0]   dcnt_q;
    logic [FC_W-1:0]   fcnt_q;
    logic [TM_W-1:0]   timer_q;
    logic              miss_q;
    logic              unlocked_q;
    logic              lockout_q;
    logic              alarm_q;
    logic [DIGIT_W-1:0] want;
    logic              miss_all;
    logic              last;
    logic              idle_hit;

    assign want     = code_q[int'(dcnt_q)*DIGIT_W +: DIGIT_W];
    assign miss_all = miss_q | (bus.Digit != want);
    assign last     = (dcnt_q == LAST);

    always_comb begin
        shadow_nxt = shadow_q;
        shadow_nxt[int'(dcnt_q)*DIGIT_W +: DIGIT_W] = bus.Digit;
    end

`ifdef COMBO_LOCK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(ENTRY_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(ENTRY_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q;
    logic              armed;

    // Armed only while a partial sequence is pending.
    assign armed = ((state_q == ENTRY) && (dcnt_q != '0)) ||
                   (state_q == PROG);
    assign idle_hit = armed && !bus.Enter && (idle_q == IDLE_LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_n || !armed || bus.Enter) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_LAST) begin
            idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ENTRY;
            code_q     <= DEFAULT_CODE;
            shadow_q   <= DEFAULT_CODE;
            dcnt_q     <= '0;
            fcnt_q     <= '0;
            timer_q    <= '0;
            miss_q     <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            alarm_q <= 1'b0;
            unique case (state_q)
                ENTRY: begin
                    if (bus.Enter && last) begin
                        dcnt_q <= '0;
                        miss_q <= 1'b0;
                        if (!miss_all) begin
                            state_q    <= OPEN;
                            unlocked_q <= 1'b1;
                            fcnt_q     <= '0;
                        end else if (fcnt_q == TRIES_M1) begin
                            state_q   <= LOCKOUT;
                            lockout_q <= 1'b1;
                            alarm_q   <= 1'b1;
                            timer_q   <= LOAD;
                            fcnt_q    <= TRIES;
                        end else begin
                            fcnt_q <= fcnt_q + 1'b1;
                        end
                    end else if (bus.Enter) begin
                        dcnt_q <= dcnt_q + 1'b1;
                        miss_q <= miss_all;
                    end else if (idle_hit) begin
                        dcnt_q <= '0;
                        miss_q <= 1'b0;
                    end
                end
                OPEN: begin
                    if (bus.Relock) begin
                        state_q    <= ENTRY;
                        unlocked_q <= 1'b0;
                    end else if (bus.Prog) begin
                        state_q    <= PROG;
                        unlocked_q <= 1'b0;
                        dcnt_q     <= '0;
                    end
                end
                PROG: begin
                    if (bus.Relock || idle_hit) begin
                        state_q <= ENTRY;
                        dcnt_q  <= '0;
                    end else if (bus.Enter) begin
                        shadow_q <= shadow_nxt;
                        if (last) begin
                            // Commit the whole code in one update.
                            code_q  <= shadow_nxt;
                            state_q <= ENTRY;
                            dcnt_q  <= '0;
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (timer_q <= TM_W'(1)) begin
                        state_q   <= ENTRY;
                        lockout_q <= 1'b0;
                        fcnt_q    <= '0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.State      = state_q;
    assign bus.Unlocked   = unlocked_q;
    assign bus.Lockout    = lockout_q;
    assign bus.Alarm      = alarm_q;
    assign bus.DigitCount = dcnt_q;
    assign bus.FailCount  = fcnt_q;
endmodule

// File: tb/tb_combination_lock_param.sv
// Directed-vector bench for combination_lock_param (default parameters).
// Also exercises the idle timeout when COMBO_LOCK_TIMEOUT_EN is defined.
module tb_combination_lock_param;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    combination_lock_param_if #(
        .DIGIT_W(4), .NUM_DIGITS(4), .MAX_TRIES(3)
    ) bus ();

    combination_lock_param #(
        .DIGIT_W(4),
        .NUM_DIGITS(4),
        .DEFAULT_CODE(16'h197D),
        .MAX_TRIES(3),
        .LOCKOUT_CYCLES(16),
        .ENTRY_TIMEOUT(64)
    ) dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        bus.Enter = 1'b1;
        bus.Digit = d;
        tick();
        bus.Enter = 1'b0;
    endtask

    task automatic code4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        key(a);
        key(b);
        key(c);
        key(d);
    endtask

    task automatic pulse_relock();
        bus.Relock = 1'b1;
        tick();
        bus.Relock = 1'b0;
    endtask

    task automatic pulse_prog();
        bus.Prog = 1'b1;
        tick();
        bus.Prog = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_state"}, bus.State, 0);
        check({tag, "_unl"}, bus.Unlocked, 0);
        check({tag, "_lko"}, bus.Lockout, 0);
        check({tag, "_alm"}, bus.Alarm, 0);
        check({tag, "_dc"}, bus.DigitCount, 0);
        check({tag, "_fc"}, bus.FailCount, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.Enter   = 1'b0;
        bus.Digit   = 4'h0;
        bus.Relock  = 1'b0;
        bus.Prog    = 1'b0;
        tick();
        tick();
        check_reset_outs("rst");
        rst_n = 1'b1;

        // Default code D,7,9,1 back-to-back
        bus.Enter = 1'b1;
        bus.Digit = 4'hD;
        tick();
        check("dc1", bus.DigitCount, 1);
        bus.Digit = 4'h7;
        tick();
        bus.Digit = 4'h9;
        tick();
        check("dc3", bus.DigitCount, 3);
        check("dc3_state", bus.State, 0);
        bus.Digit = 4'h1;
        tick();
        bus.Enter = 1'b0;
        check("open_state", bus.State, 1);
        check("open_unl", bus.Unlocked, 1);
        check("open_fc", bus.FailCount, 0);
        check("open_dc", bus.DigitCount, 0);

        key(4'h2);
        check("open_enter_ign", bus.State, 1);
        check("open_enter_dc", bus.DigitCount, 0);

        pulse_relock();
        check("relock_state", bus.State, 0);
        check("relock_unl", bus.Unlocked, 0);

        // Three wrong attempts -> lockout
        code4(4'hD, 4'h7, 4'h9, 4'h0);
        check("fail1_fc", bus.FailCount, 1);
        check("fail1_state", bus.State, 0);
        check("fail1_dc", bus.DigitCount, 0);
        code4(4'hD, 4'h7, 4'h9, 4'h0);
        check("fail2_fc", bus.FailCount, 2);
        code4(4'hD, 4'h7, 4'h9, 4'h0);
        check("lk_state", bus.State, 3);
        check("lk_alarm", bus.Alarm, 1);
        check("lk_lockout", bus.Lockout, 1);
        check("lk_fc", bus.FailCount, 3);
        check("lk_unl", bus.Unlocked, 0);

        // Cycles 2..16 of lockout with Enter hammered
        for (int i = 2; i <= 16; i++) begin
            bus.Enter = 1'b1;
            bus.Digit = 4'(i);
            bus.Prog  = 1'b1;
            tick();
            check($sformatf("lk_cyc%0d", i), bus.Lockout, 1);
            if (i == 2) check("lk_alarm_off", bus.Alarm, 0);
        end
        check("lk_end_state", bus.State, 3);
        tick();
        bus.Enter = 1'b0;
        bus.Prog  = 1'b0;
        check("lk_exit_state", bus.State, 0);
        check("lk_exit_lko", bus.Lockout, 0);
        check("lk_exit_fc", bus.FailCount, 0);
        check("lk_exit_dc", bus.DigitCount, 0);

        code4(4'hD, 4'h7, 4'h9, 4'h1);
        check("post_lk_open", bus.Unlocked, 1);

        // Reprogram to 3,3,4,4 (code 16'h4433)
        pulse_prog();
        check("prog_state", bus.State, 2);
        check("prog_unl", bus.Unlocked, 0);
        check("prog_dc0", bus.DigitCount, 0);
        key(4'h3);
        key(4'h3);
        check("prog_dc2", bus.DigitCount, 2);
        key(4'h4);
        key(4'h4);
        check("prog_done_state", bus.State, 0);
        check("prog_done_dc", bus.DigitCount, 0);
        code4(4'hD, 4'h7, 4'h9, 4'h1);
        check("old_code_state", bus.State, 0);
        check("old_code_fc", bus.FailCount, 1);
        code4(4'h3, 4'h3, 4'h4, 4'h4);
        check("new_code_state", bus.State, 1);
        check("new_code_fc", bus.FailCount, 0);

        // Relock wins over Prog
        bus.Prog = 1'b1;
        pulse_relock();
        bus.Prog = 1'b0;
        check("relock_prio", bus.State, 0);

        // Aborted reprogramming keeps 16'h4433
        code4(4'h3, 4'h3, 4'h4, 4'h4);
        pulse_prog();
        key(4'h5);
        key(4'h6);
        bus.Enter = 1'b1;
        pulse_relock();
        bus.Enter = 1'b0;
        check("abort_state", bus.State, 0);
        check("abort_dc", bus.DigitCount, 0);
        code4(4'h3, 4'h3, 4'h4, 4'h4);
        check("abort_keep", bus.Unlocked, 1);

        // Reset mid-PROG and mid-entry
        pulse_prog();
        key(4'h8);
        key(4'h8);
        rst_n = 1'b0;
        tick();
        check_reset_outs("rst_prog");
        rst_n = 1'b1;
        key(4'hD);
        key(4'h7);
        rst_n = 1'b0;
        tick();
        check_reset_outs("rst_entry");
        rst_n = 1'b1;
        code4(4'h3, 4'h3, 4'h4, 4'h4);
        check("rst_lost_code", bus.FailCount, 1);
        code4(4'hD, 4'h7, 4'h9, 4'h1);
        check("rst_default", bus.Unlocked, 1);
        check("rst_default_fc", bus.FailCount, 0);
        pulse_relock();

`ifdef COMBO_LOCK_TIMEOUT_EN
        key(4'hD);
        key(4'h7);
        repeat (63) tick();
        check("to_before", bus.DigitCount, 2);
        tick();
        check("to_dc", bus.DigitCount, 0);
        check("to_fc", bus.FailCount, 0);
        code4(4'hD, 4'h7, 4'h9, 4'h1);
        check("to_unlock", bus.Unlocked, 1);
        pulse_prog();
        key(4'h2);
        repeat (64) tick();
        check("to_prog_abort", bus.State, 0);
        code4(4'hD, 4'h7, 4'h9, 4'h1);
        check("to_prog_keep", bus.Unlocked, 1);
`else
        key(4'hD);
        key(4'h7);
        repeat (100) tick();
        check("persist_dc", bus.DigitCount, 2);
        key(4'h9);
        key(4'h1);
        check("persist_unlock", bus.Unlocked, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
